// File: rtl/regfile_nr1w_if.sv
// ============================================================================
// Module      : regfile_nr1w_if
// Description : Write/read/config bundle of the N-read 1-write register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface regfile_nr1w_if #(
  parameter int DATA_WIDTH   = 4,
  parameter int ADDR_WIDTH   = 5,
  parameter int NUM_RD       = 2,
  parameter int NoConfigBits = 2
);
  logic [DATA_WIDTH-1:0]        D;
  logic [ADDR_WIDTH-1:0]        W_ADR;
  logic                         W_en;
  logic [NUM_RD*ADDR_WIDTH-1:0] RD_ADR;
  logic [NUM_RD*DATA_WIDTH-1:0] RD_DATA;
  logic                         CLR_BUSY;
  logic [NoConfigBits-1:0]      ConfigBits;

  modport master (
    output D, W_ADR, W_en, RD_ADR, ConfigBits,
    input  RD_DATA, CLR_BUSY
  );

  modport slave (
    input  D, W_ADR, W_en, RD_ADR, ConfigBits,
    output RD_DATA, CLR_BUSY
  );
endinterface

`default_nettype wire

// File: rtl/regfile_nr1w.sv
// ============================================================================
// Module      : regfile_nr1w
// Description : 2^ADDR_WIDTH x DATA_WIDTH register file, one write port and
//               NUM_RD read ports (each combinational or registered), with a
//               post-reset clear sweep. Macro REGFILE_WR_BYPASS_EN selects
//               write-first reads; default is read-before-write.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_nr1w #(
  parameter int DATA_WIDTH   = 4,
  parameter int ADDR_WIDTH   = 5,
  parameter int NUM_RD       = 2,
  parameter int NoConfigBits = 2
) (
  input  wire logic      UserCLK,
  input  wire logic      UserRSTn,
  regfile_nr1w_if.slave  bus
);

  localparam int                    c_DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] c_LAST  = '1;
  localparam logic [ADDR_WIDTH-1:0] c_ONE   = ADDR_WIDTH'(1);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_clr_ptr;
  logic                  r_clr_busy;
  logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];

  // Clear sweep owns the array until the last entry is zeroed; user writes
  // are only honoured once in IDLE.
  always_ff @(posedge UserCLK) begin
    if (!UserRSTn) begin
      r_state    <= ST_CLEAR;
      r_clr_ptr  <= '0;
      r_clr_busy <= 1'b1;
      r_mem[0]   <= '0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_mem[r_clr_ptr] <= '0;
          r_clr_ptr        <= r_clr_ptr + c_ONE;
          if (r_clr_ptr == c_LAST) begin
            r_state    <= ST_IDLE;
            r_clr_busy <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (bus.W_en) begin
            r_mem[bus.W_ADR] <= bus.D;
          end
        end
        default: begin
          r_state    <= ST_CLEAR;
          r_clr_ptr  <= '0;
          r_clr_busy <= 1'b1;
        end
      endcase
    end
  end

  assign bus.CLR_BUSY = r_clr_busy;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_val;
    logic [DATA_WIDTH-1:0] r_q;

    assign w_addr = bus.RD_ADR[p*ADDR_WIDTH +: ADDR_WIDTH];

`ifdef REGFILE_WR_BYPASS_EN
    assign w_val = ((r_state == ST_IDLE) && bus.W_en && (w_addr == bus.W_ADR))
                   ? bus.D : r_mem[w_addr];
`else
    assign w_val = r_mem[w_addr];
`endif

    always_ff @(posedge UserCLK) begin
      if (!UserRSTn) begin
        r_q <= '0;
      end else begin
        r_q <= w_val;
      end
    end

    assign bus.RD_DATA[p*DATA_WIDTH +: DATA_WIDTH] = bus.ConfigBits[p] ? r_q : w_val;
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_nr1w.sv
// ============================================================================
// Module      : tb_regfile_nr1w
// Description : Scoreboard bench for regfile_nr1w, default and 8x8/4-port builds.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_nr1w;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn_a;
  logic rstn_b;

  regfile_nr1w_if #(.DATA_WIDTH(4), .ADDR_WIDTH(5), .NUM_RD(2), .NoConfigBits(2)) bus_a ();
  regfile_nr1w_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .NUM_RD(4), .NoConfigBits(4)) bus_b ();

  regfile_nr1w #(.DATA_WIDTH(4), .ADDR_WIDTH(5), .NUM_RD(2), .NoConfigBits(2)) u_dut_a (
    .UserCLK  (clk),
    .UserRSTn (rstn_a),
    .bus      (bus_a)
  );

  regfile_nr1w #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .NUM_RD(4), .NoConfigBits(4)) u_dut_b (
    .UserCLK  (clk),
    .UserRSTn (rstn_b),
    .bus      (bus_b)
  );

`ifdef REGFILE_WR_BYPASS_EN
  localparam logic [31:0] c_SAME_ADDR_EXP = 32'h9;
`else
  localparam logic [31:0] c_SAME_ADDR_EXP = 32'h2;
`endif

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] q_exp [$];
  string       q_tag [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic sb_push(input string tag, input logic [31:0] exp);
    q_tag.push_back(tag);
    q_exp.push_back(exp);
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    if (q_exp.size() == 0) begin
      chk("sb_underflow", 32'(q_exp.size()), 32'd1);
    end else begin
      chk(q_tag.pop_front(), obs, q_exp.pop_front());
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rd_a(input int p);
    return 32'(bus_a.RD_DATA[p*4 +: 4]);
  endfunction

  function automatic logic [31:0] rd_b(input int p);
    return 32'(bus_b.RD_DATA[p*8 +: 8]);
  endfunction

  task automatic wr_a(input logic [4:0] addr, input logic [3:0] data);
    bus_a.W_en  = 1'b1;
    bus_a.W_ADR = addr;
    bus_a.D     = data;
    tick();
    bus_a.W_en  = 1'b0;
  endtask

  // Edges from now until CLR_BUSY is seen low, bounded.
  task automatic count_busy(input bit sel_b, output int cnt);
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      cnt++;
      if (!(sel_b ? bus_b.CLR_BUSY : bus_a.CLR_BUSY)) break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    rstn_a = 1'b0;
    rstn_b = 1'b0;
    bus_a.D = '0; bus_a.W_ADR = '0; bus_a.W_en = 1'b0; bus_a.RD_ADR = '0;
    bus_a.ConfigBits = 2'b10;
    bus_b.D = '0; bus_b.W_ADR = '0; bus_b.W_en = 1'b0; bus_b.RD_ADR = '0;
    bus_b.ConfigBits = 4'b1010;
    tick(); tick();

    sb_push("rst_busy", 32'd1);   sb_pop(32'(bus_a.CLR_BUSY));
    sb_push("rst_port1", 32'd0);  sb_pop(rd_a(1));

    rstn_a = 1'b1;
    sb_push("clr_len0", 32'd32);
    count_busy(1'b0, cnt);
    sb_pop(32'(cnt));

    // Fill, then reset for 3 cycles with a write held during the sweep
    for (int i = 0; i < 32; i++) wr_a(5'(i), 4'hA);
    bus_a.RD_ADR = {5'd17, 5'd17};
    #1;
    sb_push("fill", 32'hA);       sb_pop(rd_a(0));

    rstn_a = 1'b0;
    repeat (3) tick();
    rstn_a = 1'b1;
    bus_a.W_en = 1'b1; bus_a.W_ADR = 5'd5; bus_a.D = 4'hF;
    sb_push("clr_len1", 32'd32);
    count_busy(1'b0, cnt);
    bus_a.W_en = 1'b0;
    sb_pop(32'(cnt));

    for (int i = 0; i < 32; i++) begin
      bus_a.RD_ADR = {5'(i), 5'(i)};
      #1;
      sb_push("clr_p0", 32'd0);   sb_pop(rd_a(0));
      tick();
      sb_push("clr_p1", 32'd0);   sb_pop(rd_a(1));
    end
    bus_a.RD_ADR = {5'd0, 5'd5};
    #1;
    sb_push("wr_in_clear", 32'd0); sb_pop(rd_a(0));

    // Write on the first cycle CLR_BUSY is low must land
    rstn_a = 1'b0; tick(); rstn_a = 1'b1;
    sb_push("clr_len2", 32'd32);
    count_busy(1'b0, cnt);
    sb_pop(32'(cnt));
    wr_a(5'd9, 4'hC);
    bus_a.RD_ADR = {5'd0, 5'd9};
    #1;
    sb_push("wr_first_idle", 32'hC); sb_pop(rd_a(0));

    // Combinational port 0 vs registered port 1
    bus_a.RD_ADR = {5'd4, 5'd4};
    wr_a(5'd3, 4'h6);
    bus_a.RD_ADR = {5'd3, 5'd3};
    #1;
    sb_push("comb_lat0", 32'h6);  sb_pop(rd_a(0));
    sb_push("reg_lat0", 32'h0);   sb_pop(rd_a(1));
    tick();
    sb_push("reg_lat1", 32'h6);   sb_pop(rd_a(1));
    rstn_a = 1'b0;
    tick();
    sb_push("reg_rst", 32'h0);    sb_pop(rd_a(1));
    sb_push("rst_comb", 32'h6);   sb_pop(rd_a(0));
    rstn_a = 1'b1;
    sb_push("clr_len3", 32'd32);
    count_busy(1'b0, cnt);
    sb_pop(32'(cnt));

    // Same-address read during write
    wr_a(5'd7, 4'h2);
    bus_a.RD_ADR = {5'd7, 5'd7};
    bus_a.W_en = 1'b1; bus_a.W_ADR = 5'd7; bus_a.D = 4'h9;
    #1;
    sb_push("same_comb", c_SAME_ADDR_EXP); sb_pop(rd_a(0));
    tick();
    bus_a.W_en = 1'b0;
    sb_push("same_reg", c_SAME_ADDR_EXP);  sb_pop(rd_a(1));
    sb_push("same_after", 32'h9);          sb_pop(rd_a(0));

    // Reset at clr_ptr == 10 restarts the full sweep
    rstn_a = 1'b0; tick(); rstn_a = 1'b1;
    repeat (10) tick();
    sb_push("mid_busy", 32'd1);   sb_pop(32'(bus_a.CLR_BUSY));
    rstn_a = 1'b0; tick(); rstn_a = 1'b1;
    sb_push("mid_len", 32'd32);
    count_busy(1'b0, cnt);
    sb_pop(32'(cnt));
    #1;
    sb_push("mid_clr", 32'd0);    sb_pop(rd_a(0));

    // 8-bit x 8-entry, 4 read ports
    rstn_b = 1'b1;
    sb_push("b_clr_len", 32'd8);
    count_busy(1'b1, cnt);
    sb_pop(32'(cnt));
    bus_b.W_en = 1'b1; bus_b.W_ADR = 3'd6; bus_b.D = 8'hA5;
    tick();
    bus_b.W_en = 1'b0;
    bus_b.RD_ADR = {4{3'd6}};
    #1;
    sb_push("b_p0", 32'hA5);      sb_pop(rd_b(0));
    sb_push("b_p2", 32'hA5);      sb_pop(rd_b(2));
    tick();
    sb_push("b_p1", 32'hA5);      sb_pop(rd_b(1));
    sb_push("b_p3", 32'hA5);      sb_pop(rd_b(3));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
